collision_scanner: RTL and testbench

Per-frame, multi-wall successor to the single-wall bird/wall collision check. On a frame `start` pulse it captures the bird bounding box. It then scans NUM_WALLS wall slots, one per clock, and reports three things: a sticky collision flag with the first offending wall index, a screen-boundary hit, and the per-frame count of newly passed walls. It sits between the game-control FSM, which pulses `start` once per frame and reacts to `hit`, and the score display, which reads `score`.

---
 rtl/collision_pkg.sv | 30 +++
 rtl/collision_scanner_if.sv | 26 ++
 rtl/wall_overlap_check.sv | 34 +++
 rtl/collision_scanner.sv | 189 ++++++++++++++++++
 tb/tb_collision_scanner.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/collision_pkg.sv
// Shared types and helpers for the multi-wall collision scanner.
// Bird coordinates are held zero-extended to CW_MAX bits.
package collision_pkg;

    localparam int CW_MAX  = 16;
    localparam int VEC_MAX = 256;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    typedef struct packed {
        logic [CW_MAX-1:0] xl;
        logic [CW_MAX-1:0] xr;
        logic [CW_MAX-1:0] yt;
        logic [CW_MAX-1:0] yb;
    } bird_t;

    // Coordinate i of a packed vector with cw-bit fields, zero-extended.
    function automatic logic [CW_MAX-1:0] slot(
        input logic [VEC_MAX-1:0] vec,
        input int unsigned        cw,
        input int unsigned        i
    );
        return CW_MAX'(vec >> (i * cw)) & CW_MAX'((32'd1 << cw) - 32'd1);
    endfunction

endpackage

// File: rtl/collision_scanner_if.sv
// Control and result bundle between the game FSM and the scanner.
interface collision_scanner_if #(
    parameter int IDX_W   = 2,
    parameter int SCORE_W = 8
);
    logic               start;
    logic               clear_hit;
    logic               clear_score;
    logic               busy;
    logic               done;
    logic               hit;
    logic [IDX_W-1:0]   hit_wall;
    logic               bound_hit;
    logic [SCORE_W-1:0] score;
    logic               score_inc;

    modport master (
        output start, clear_hit, clear_score,
        input  busy, done, hit, hit_wall, bound_hit, score, score_inc
    );

    modport slave (
        input  start, clear_hit, clear_score,
        output busy, done, hit, hit_wall, bound_hit, score, score_inc
    );
endinterface

// File: rtl/wall_overlap_check.sv
// Combinational bird-versus-single-wall test: collision, pass and re-arm.
module wall_overlap_check #(
    parameter int COORD_W   = 8,
    parameter int INCLUSIVE = 1
) (
    input  logic [COORD_W-1:0] i_bird_xl,
    input  logic [COORD_W-1:0] i_bird_xr,
    input  logic [COORD_W-1:0] i_bird_yt,
    input  logic [COORD_W-1:0] i_bird_yb,
    input  logic [COORD_W-1:0] i_wall_xl,
    input  logic [COORD_W-1:0] i_wall_xr,
    input  logic [COORD_W-1:0] i_wall_yt,
    input  logic [COORD_W-1:0] i_wall_yb,
    output logic               collide,
    output logic               passed_now,
    output logic               rearm
);
    logic w_in_x;
    logic w_touch_y;

    if (INCLUSIVE != 0) begin : g_incl
        assign w_in_x    = (i_bird_xr >= i_wall_xl) && (i_bird_xl <= i_wall_xr);
        assign w_touch_y = (i_bird_yt <= i_wall_yt) || (i_bird_yb >= i_wall_yb);
    end else begin : g_strict
        assign w_in_x    = (i_bird_xr > i_wall_xl) && (i_bird_xl < i_wall_xr);
        assign w_touch_y = (i_bird_yt < i_wall_yt) || (i_bird_yb > i_wall_yb);
    end

    assign collide    = w_in_x && w_touch_y;
    assign passed_now = i_bird_xl > i_wall_xr;
    // Bird entirely left of the wall: the slot has respawned ahead of it.
    assign rearm      = i_bird_xr < i_wall_xl;

endmodule

// File: rtl/collision_scanner.sv
// Per-frame scan of NUM_WALLS wall slots against a snapshotted bird box,
// producing sticky hit/boundary flags and a saturating pass score.
module collision_scanner
    import collision_pkg::*;
#(
    parameter int COORD_W   = 8,
    parameter int NUM_WALLS = 4,
    parameter int IDX_W     = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1,
    parameter int SCREEN_H  = 120,
    parameter int SCORE_W   = 8,
    parameter int INCLUSIVE = 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [COORD_W-1:0]           bird_xleft,
    input  logic [COORD_W-1:0]           bird_xright,
    input  logic [COORD_W-1:0]           bird_ytop,
    input  logic [COORD_W-1:0]           bird_ybottom,
    input  logic [NUM_WALLS*COORD_W-1:0] wall_xleft,
    input  logic [NUM_WALLS*COORD_W-1:0] wall_xright,
    input  logic [NUM_WALLS*COORD_W-1:0] wall_topy,
    input  logic [NUM_WALLS*COORD_W-1:0] wall_bottomy,
    collision_scanner_if.slave           bus
);
    localparam int CNT_W = $clog2(NUM_WALLS + 1);
    localparam int SUM_W = SCORE_W + CNT_W;

    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_WALLS - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [CW_MAX-1:0]  Y_BOT     = CW_MAX'(SCREEN_H - 1);

    state_t               r_state;
    state_t               w_next;
    bird_t                r_bird;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_f_hit;
    logic [IDX_W-1:0]     r_f_idx;
    logic [CNT_W-1:0]     r_f_cnt;
    logic [NUM_WALLS-1:0] r_passed;
    logic                 r_hit;
    logic [IDX_W-1:0]     r_hit_wall;
    logic                 r_bound;
    logic [SCORE_W-1:0]   r_score;

    logic                 w_busy;
    logic                 w_done;
    logic                 w_collide;
    logic                 w_pass_now;
    logic                 w_rearm;
    logic                 w_bound;
    logic                 w_score_inc;
    logic [SUM_W-1:0]     w_sum;
    logic [SCORE_W-1:0]   w_score_sat;
    logic [CW_MAX-1:0]    w_wxl;
    logic [CW_MAX-1:0]    w_wxr;
    logic [CW_MAX-1:0]    w_wyt;
    logic [CW_MAX-1:0]    w_wyb;

    assign w_wxl = slot(VEC_MAX'(wall_xleft),   COORD_W, 32'(r_idx));
    assign w_wxr = slot(VEC_MAX'(wall_xright),  COORD_W, 32'(r_idx));
    assign w_wyt = slot(VEC_MAX'(wall_topy),    COORD_W, 32'(r_idx));
    assign w_wyb = slot(VEC_MAX'(wall_bottomy), COORD_W, 32'(r_idx));

    // Zero-extended operands give the same unsigned result as COORD_W compares.
    wall_overlap_check #(
        .COORD_W   (CW_MAX),
        .INCLUSIVE (INCLUSIVE)
    ) u_check (
        .i_bird_xl  (r_bird.xl),
        .i_bird_xr  (r_bird.xr),
        .i_bird_yt  (r_bird.yt),
        .i_bird_yb  (r_bird.yb),
        .i_wall_xl  (w_wxl),
        .i_wall_xr  (w_wxr),
        .i_wall_yt  (w_wyt),
        .i_wall_yb  (w_wyb),
        .collide    (w_collide),
        .passed_now (w_pass_now),
        .rearm      (w_rearm)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start) w_next = SCAN;
            end
            SCAN: begin
                w_busy = 1'b1;
                if (r_idx == IDX_LAST) w_next = DONE;
            end
            DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bird   <= '0;
            r_idx    <= '0;
            r_f_hit  <= 1'b0;
            r_f_idx  <= '0;
            r_f_cnt  <= '0;
            r_passed <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_bird.xl <= CW_MAX'(bird_xleft);
                        r_bird.xr <= CW_MAX'(bird_xright);
                        r_bird.yt <= CW_MAX'(bird_ytop);
                        r_bird.yb <= CW_MAX'(bird_ybottom);
                        r_idx     <= '0;
                        r_f_hit   <= 1'b0;
                        r_f_idx   <= '0;
                        r_f_cnt   <= '0;
                    end
                end
                SCAN: begin
                    if (r_idx != IDX_LAST) r_idx <= r_idx + IDX_W'(1);
                    if (w_collide && !r_f_hit) begin
                        r_f_hit <= 1'b1;
                        r_f_idx <= r_idx;
                    end
                    if (w_pass_now && !r_passed[r_idx]) begin
                        r_passed[r_idx] <= 1'b1;
                        r_f_cnt         <= r_f_cnt + CNT_W'(1);
                    end else if (w_rearm) begin
                        r_passed[r_idx] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_bound     = (r_bird.yt == '0) || (r_bird.yb >= Y_BOT);
    assign w_sum       = SUM_W'(r_score) + SUM_W'(r_f_cnt);
    assign w_score_sat = (w_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX
                                                     : w_sum[SCORE_W-1:0];
    // A same-cycle clear_score suppresses the increment entirely.
    assign w_score_inc = w_done && !r_f_hit && (r_f_cnt != '0)
                         && !bus.clear_score;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hit      <= 1'b0;
            r_hit_wall <= '0;
            r_bound    <= 1'b0;
            r_score    <= '0;
        end else begin
            if (bus.clear_hit) begin
                r_hit      <= 1'b0;
                r_hit_wall <= '0;
                r_bound    <= 1'b0;
            end
            if (bus.clear_score) r_score <= '0;
            // Frame results land after clears so a coincident set wins.
            if (w_done) begin
                if (r_f_hit) begin
                    r_hit <= 1'b1;
                    if (!r_hit || bus.clear_hit) r_hit_wall <= r_f_idx;
                end
                if (w_bound) r_bound <= 1'b1;
                if (w_score_inc) r_score <= w_score_sat;
            end
        end
    end

    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.hit       = r_hit;
    assign bus.hit_wall  = r_hit_wall;
    assign bus.bound_hit = r_bound;
    assign bus.score     = r_score;
    assign bus.score_inc = w_score_inc;

endmodule

// File: tb/tb_collision_scanner.sv
// Directed bench for collision_scanner: default, strict-edge and
// 2-bit-score instances share bird/wall stimulus.
module tb_collision_scanner;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  bxl, bxr, byt, byb;
    logic [31:0] wxl, wxr, wyt, wyb;

    int checks = 0;
    int errors = 0;

    collision_scanner_if #(.IDX_W(2), .SCORE_W(8)) b0 ();
    collision_scanner_if #(.IDX_W(2), .SCORE_W(8)) b1 ();
    collision_scanner_if #(.IDX_W(2), .SCORE_W(2)) b2 ();

    always #5 clk = ~clk;

    collision_scanner #(.INCLUSIVE(1)) u_dut (
        .clk(clk), .resetn(resetn),
        .bird_xleft(bxl), .bird_xright(bxr),
        .bird_ytop(byt), .bird_ybottom(byb),
        .wall_xleft(wxl), .wall_xright(wxr),
        .wall_topy(wyt), .wall_bottomy(wyb),
        .bus(b0)
    );

    collision_scanner #(.INCLUSIVE(0)) u_strict (
        .clk(clk), .resetn(resetn),
        .bird_xleft(bxl), .bird_xright(bxr),
        .bird_ytop(byt), .bird_ybottom(byb),
        .wall_xleft(wxl), .wall_xright(wxr),
        .wall_topy(wyt), .wall_bottomy(wyb),
        .bus(b1)
    );

    collision_scanner #(.SCORE_W(2)) u_sat (
        .clk(clk), .resetn(resetn),
        .bird_xleft(bxl), .bird_xright(bxr),
        .bird_ytop(byt), .bird_ybottom(byb),
        .wall_xleft(wxl), .wall_xright(wxr),
        .wall_topy(wyt), .wall_bottomy(wyb),
        .bus(b2)
    );

    task automatic set_wall(input int i, input logic [7:0] xl,
                            input logic [7:0] xr, input logic [7:0] yt,
                            input logic [7:0] yb);
        wxl[i*8 +: 8] = xl;
        wxr[i*8 +: 8] = xr;
        wyt[i*8 +: 8] = yt;
        wyb[i*8 +: 8] = yb;
    endtask

    task automatic walls_far();
        for (int i = 0; i < 4; i++) set_wall(i, 8'd100, 8'd115, 8'd40, 8'd70);
    endtask

    task automatic bird_default();
        bxl = 8'd10; bxr = 8'd17; byt = 8'd50; byb = 8'd57;
    endtask

    task automatic set_start(input int d, input logic v);
        case (d)
            0:       b0.start = v;
            1:       b1.start = v;
            default: b2.start = v;
        endcase
    endtask

    task automatic set_clr_score(input int d, input logic v);
        case (d)
            0:       b0.clear_score = v;
            1:       b1.clear_score = v;
            default: b2.clear_score = v;
        endcase
    endtask

    task automatic set_clr_hit(input logic v);
        b0.clear_hit = v;
        b1.clear_hit = v;
        b2.clear_hit = v;
    endtask

    function automatic logic get_done(input int d);
        case (d)
            0:       return b0.done;
            1:       return b1.done;
            default: return b2.done;
        endcase
    endfunction

    function automatic logic get_busy(input int d);
        case (d)
            0:       return b0.busy;
            1:       return b1.busy;
            default: return b2.busy;
        endcase
    endfunction

    function automatic logic get_inc(input int d);
        case (d)
            0:       return b0.score_inc;
            1:       return b1.score_inc;
            default: return b2.score_inc;
        endcase
    endfunction

    // Pulse start, find done (cycle count from the start cycle), optionally
    // raise clears during the done cycle, return one cycle after done.
    task automatic run_frame(input int d, input bit chit, input bit cscore,
                             output int lat, output logic inc,
                             output logic busy1);
        lat = 0;
        inc = 1'b0;
        busy1 = 1'b0;
        @(posedge clk); #1; set_start(d, 1'b1);
        @(posedge clk); #1; set_start(d, 1'b0);
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) busy1 = get_busy(d);
            if (get_done(d)) begin
                if (chit) set_clr_hit(1'b1);
                if (cscore) set_clr_score(d, 1'b1);
                #1;
                inc = get_inc(d);
                lat = c;
            end
        end
        @(posedge clk); #1;
        set_clr_hit(1'b0);
        set_clr_score(d, 1'b0);
    endtask

    task automatic pulse_clear_hit();
        @(posedge clk); #1; set_clr_hit(1'b1);
        @(posedge clk); #1; set_clr_hit(1'b0);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({b0.busy, b0.done, b0.hit, b0.bound_hit, b0.score_inc} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {b0.busy, b0.done, b0.hit, b0.bound_hit, b0.score_inc});
        end
        checks++;
        if (b0.score !== 8'd0 || b0.hit_wall !== 2'd0) begin
            errors++;
            $display("FAIL reset_score: got score=%0d hit_wall=%0d expected 0 0",
                     b0.score, b0.hit_wall);
        end
        @(negedge clk); resetn = 1'b1;
    endtask

    task automatic test_idle_frame();
        int lat; logic inc; logic bz;
        bird_default(); walls_far();
        run_frame(0, 0, 0, lat, inc, bz);
        checks++;
        if (lat !== 5) begin
            errors++; $display("FAIL idle_latency: got %0d expected 5", lat);
        end
        checks++;
        if (bz !== 1'b1) begin
            errors++; $display("FAIL idle_busy: got %b expected 1", bz);
        end
        checks++;
        if ({b0.hit, b0.bound_hit, b0.busy, inc} !== 4'b0 || b0.score !== 8'd0) begin
            errors++;
            $display("FAIL idle_results: got hit=%b bound=%b busy=%b inc=%b score=%0d expected all 0",
                     b0.hit, b0.bound_hit, b0.busy, inc, b0.score);
        end
    endtask

    task automatic test_collision_index();
        int lat; logic inc; logic bz;
        set_wall(2, 8'd12, 8'd27, 8'd55, 8'd70);
        set_wall(3, 8'd12, 8'd27, 8'd55, 8'd70);
        run_frame(0, 0, 0, lat, inc, bz);
        checks++;
        if (b0.hit !== 1'b1 || b0.hit_wall !== 2'd2) begin
            errors++;
            $display("FAIL coll_index: got hit=%b wall=%0d expected 1 2",
                     b0.hit, b0.hit_wall);
        end
        checks++;
        if (b0.score !== 8'd0 || inc !== 1'b0) begin
            errors++;
            $display("FAIL coll_score: got score=%0d inc=%b expected 0 0",
                     b0.score, inc);
        end
        walls_far();
        set_wall(0, 8'd17, 8'd32, 8'd50, 8'd70);
        run_frame(0, 0, 0, lat, inc, bz);
        checks++;
        if (b0.hit !== 1'b1 || b0.hit_wall !== 2'd2) begin
            errors++;
            $display("FAIL coll_sticky: got hit=%b wall=%0d expected 1 2",
                     b0.hit, b0.hit_wall);
        end
        pulse_clear_hit();
        checks++;
        if (b0.hit !== 1'b0 || b0.hit_wall !== 2'd0) begin
            errors++;
            $display("FAIL coll_clear: got hit=%b wall=%0d expected 0 0",
                     b0.hit, b0.hit_wall);
        end
    endtask

    task automatic test_edge_contact();
        int lat; logic inc; logic bz;
        walls_far();
        set_wall(0, 8'd17, 8'd32, 8'd50, 8'd70);
        run_frame(0, 0, 0, lat, inc, bz);
        checks++;
        if (b0.hit !== 1'b1 || b0.hit_wall !== 2'd0) begin
            errors++;
            $display("FAIL edge_incl: got hit=%b wall=%0d expected 1 0",
                     b0.hit, b0.hit_wall);
        end
        run_frame(1, 0, 0, lat, inc, bz);
        checks++;
        if (lat !== 5 || b1.hit !== 1'b0) begin
            errors++;
            $display("FAIL edge_strict: got lat=%0d hit=%b expected 5 0",
                     lat, b1.hit);
        end
        // Clear in the same cycle as a new set: the set and new index win.
        walls_far();
        set_wall(2, 8'd12, 8'd27, 8'd55, 8'd70);
        run_frame(0, 1, 0, lat, inc, bz);
        checks++;
        if (b0.hit !== 1'b1 || b0.hit_wall !== 2'd2) begin
            errors++;
            $display("FAIL clear_vs_set: got hit=%b wall=%0d expected 1 2",
                     b0.hit, b0.hit_wall);
        end
        pulse_clear_hit();
        walls_far();
    endtask

    task automatic test_pass_rearm();
        int lat; logic inc; logic bz;
        walls_far();
        set_wall(1, 8'd0, 8'd8, 8'd40, 8'd70);
        run_frame(0, 0, 0, lat, inc, bz);
        checks++;
        if (b0.score !== 8'd1 || inc !== 1'b1 || b0.hit !== 1'b0) begin
            errors++;
            $display("FAIL pass_first: got score=%0d inc=%b hit=%b expected 1 1 0",
                     b0.score, inc, b0.hit);
        end
        run_frame(0, 0, 0, lat, inc, bz);
        checks++;
        if (b0.score !== 8'd1 || inc !== 1'b0) begin
            errors++;
            $display("FAIL pass_repeat: got score=%0d inc=%b expected 1 0",
                     b0.score, inc);
        end
        set_wall(1, 8'd100, 8'd115, 8'd40, 8'd70);
        run_frame(0, 0, 0, lat, inc, bz);
        set_wall(1, 8'd0, 8'd8, 8'd40, 8'd70);
        run_frame(0, 0, 0, lat, inc, bz);
        checks++;
        if (b0.score !== 8'd2 || inc !== 1'b1) begin
            errors++;
            $display("FAIL pass_rearm: got score=%0d inc=%b expected 2 1",
                     b0.score, inc);
        end
        set_wall(1, 8'd100, 8'd115, 8'd40, 8'd70);
        run_frame(0, 0, 0, lat, inc, bz);
        set_wall(1, 8'd0, 8'd8, 8'd40, 8'd70);
        set_wall(2, 8'd12, 8'd27, 8'd55, 8'd70);
        run_frame(0, 0, 0, lat, inc, bz);
        checks++;
        if (b0.score !== 8'd2 || inc !== 1'b0 || b0.hit !== 1'b1) begin
            errors++;
            $display("FAIL hit_no_score: got score=%0d inc=%b hit=%b expected 2 0 1",
                     b0.score, inc, b0.hit);
        end
        pulse_clear_hit();
        walls_far();
    endtask

    task automatic test_saturation();
        int lat; logic inc; logic bz;
        for (int i = 0; i < 4; i++) set_wall(i, 8'd0, 8'd8, 8'd40, 8'd70);
        run_frame(2, 0, 0, lat, inc, bz);
        checks++;
        if (b2.score !== 2'd3 || inc !== 1'b1) begin
            errors++;
            $display("FAIL sat_four: got score=%0d inc=%b expected 3 1",
                     b2.score, inc);
        end
        walls_far();
        run_frame(2, 0, 0, lat, inc, bz);
        set_wall(1, 8'd0, 8'd8, 8'd40, 8'd70);
        run_frame(2, 0, 0, lat, inc, bz);
        checks++;
        if (b2.score !== 2'd3) begin
            errors++; $display("FAIL sat_hold: got %0d expected 3", b2.score);
        end
        walls_far();
        run_frame(2, 0, 0, lat, inc, bz);
        set_wall(1, 8'd0, 8'd8, 8'd40, 8'd70);
        run_frame(2, 0, 1, lat, inc, bz);
        checks++;
        if (b2.score !== 2'd0 || inc !== 1'b0) begin
            errors++;
            $display("FAIL clr_vs_inc: got score=%0d inc=%b expected 0 0",
                     b2.score, inc);
        end
        walls_far();
    endtask

    task automatic test_start_ignored();
        int ndone; int first;
        ndone = 0;
        first = 0;
        bird_default(); walls_far();
        @(posedge clk); #1; b0.start = 1'b1;
        @(posedge clk); #1; b0.start = 1'b0;
        @(posedge clk); #1; b0.start = 1'b1;
        @(posedge clk); #1; b0.start = 1'b0;
        for (int c = 3; c <= 16; c++) begin
            @(negedge clk);
            if (b0.done) begin
                ndone++;
                if (first == 0) first = c;
            end
        end
        checks++;
        if (ndone !== 1 || first !== 5) begin
            errors++;
            $display("FAIL start_busy: got dones=%0d at=%0d expected 1 5",
                     ndone, first);
        end
    endtask

    task automatic test_boundary();
        int lat; logic inc; logic bz;
        bird_default(); walls_far();
        byb = 8'd118;
        run_frame(0, 0, 0, lat, inc, bz);
        checks++;
        if (b0.bound_hit !== 1'b0) begin
            errors++; $display("FAIL bound_118: got %b expected 0", b0.bound_hit);
        end
        byb = 8'd119;
        run_frame(0, 0, 0, lat, inc, bz);
        checks++;
        if (b0.bound_hit !== 1'b1 || b0.hit !== 1'b0) begin
            errors++;
            $display("FAIL bound_119: got bound=%b hit=%b expected 1 0",
                     b0.bound_hit, b0.hit);
        end
        pulse_clear_hit();
        checks++;
        if (b0.bound_hit !== 1'b0) begin
            errors++; $display("FAIL bound_clear: got %b expected 0", b0.bound_hit);
        end
        byt = 8'd0; byb = 8'd57;
        run_frame(0, 0, 0, lat, inc, bz);
        checks++;
        if (b0.bound_hit !== 1'b1) begin
            errors++; $display("FAIL bound_top: got %b expected 1", b0.bound_hit);
        end
        bird_default();
    endtask

    task automatic test_async_reset();
        int ndone;
        ndone = 0;
        @(posedge clk); #1; b0.start = 1'b1;
        @(posedge clk); #1; b0.start = 1'b0;
        @(posedge clk); #2;
        checks++;
        if (b0.busy !== 1'b1) begin
            errors++; $display("FAIL rst_pre_busy: got %b expected 1", b0.busy);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({b0.busy, b0.done, b0.hit, b0.bound_hit, b0.score_inc} !== 5'b0
            || b0.score !== 8'd0 || b0.hit_wall !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid_scan: got busy=%b done=%b hit=%b bound=%b score=%0d expected all 0",
                     b0.busy, b0.done, b0.hit, b0.bound_hit, b0.score);
        end
        @(negedge clk); resetn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (b0.done || b0.busy) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL rst_no_done: got %0d active cycles expected 0", ndone);
        end
    endtask

    initial begin
        b0.start = 1'b0; b0.clear_hit = 1'b0; b0.clear_score = 1'b0;
        b1.start = 1'b0; b1.clear_hit = 1'b0; b1.clear_score = 1'b0;
        b2.start = 1'b0; b2.clear_hit = 1'b0; b2.clear_score = 1'b0;
        bird_default();
        walls_far();
        test_reset();
        test_idle_frame();
        test_collision_index();
        test_edge_contact();
        test_pass_rearm();
        test_saturation();
        test_start_ignored();
        test_boundary();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
